// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle RV32I core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// ALU, select muxes, write enables and the shared-memory handshake.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lsb,
    input  logic        mem_rvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic [3:0]  alu_ctrl,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  imm_sel,
    output logic        aluout_we,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] reset_pc,
    output logic        illegal
);

    // ALU operation codes shared with the RV32I ALU
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SRL    = 4'd5;
    localparam logic [3:0] ALU_SRA    = 4'd6;
    localparam logic [3:0] ALU_OR     = 4'd7;
    localparam logic [3:0] ALU_AND    = 4'd8;
    localparam logic [3:0] ALU_PASS_B = 4'd9;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH,
        C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
    } class_t;

    state_t      r_state;
    class_t      w_class;
    logic [3:0]  w_aluOp;
    logic        w_taken;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_f7Zero;
    logic        w_f7Alt;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_f7Zero = (instr[31:25] == 7'b0000000);
    assign w_f7Alt  = (instr[31:25] == 7'b0100000);
    assign reset_pc = RESET_PC;

    // Classify the IR and pick the R/I ALU op; anything the ALU cannot do
    // (unsigned compares, FENCE, SYSTEM, non-word memory ops) is illegal.
    always_comb begin
        w_class = C_ILLEGAL;
        w_aluOp = ALU_ADD;
        case (w_opcode)
            OP_R: begin
                case (w_funct3)
                    3'b000: begin
                        if (w_f7Zero) begin
                            w_class = C_ALU_R;
                            w_aluOp = ALU_ADD;
                        end else if (w_f7Alt) begin
                            w_class = C_ALU_R;
                            w_aluOp = ALU_SUB;
                        end
                    end
                    3'b001: if (w_f7Zero) begin w_class = C_ALU_R; w_aluOp = ALU_SLL; end
                    3'b010: if (w_f7Zero) begin w_class = C_ALU_R; w_aluOp = ALU_SLT; end
                    3'b100: if (w_f7Zero) begin w_class = C_ALU_R; w_aluOp = ALU_XOR; end
                    3'b101: begin
                        if (w_f7Zero) begin
                            w_class = C_ALU_R;
                            w_aluOp = ALU_SRL;
                        end else if (w_f7Alt) begin
                            w_class = C_ALU_R;
                            w_aluOp = ALU_SRA;
                        end
                    end
                    3'b110: if (w_f7Zero) begin w_class = C_ALU_R; w_aluOp = ALU_OR; end
                    3'b111: if (w_f7Zero) begin w_class = C_ALU_R; w_aluOp = ALU_AND; end
                    default: w_class = C_ILLEGAL;
                endcase
            end
            OP_I: begin
                case (w_funct3)
                    3'b000: begin w_class = C_ALU_I; w_aluOp = ALU_ADD; end
                    3'b010: begin w_class = C_ALU_I; w_aluOp = ALU_SLT; end
                    3'b100: begin w_class = C_ALU_I; w_aluOp = ALU_XOR; end
                    3'b110: begin w_class = C_ALU_I; w_aluOp = ALU_OR;  end
                    3'b111: begin w_class = C_ALU_I; w_aluOp = ALU_AND; end
                    3'b001: if (w_f7Zero) begin w_class = C_ALU_I; w_aluOp = ALU_SLL; end
                    3'b101: begin
                        if (w_f7Zero) begin
                            w_class = C_ALU_I;
                            w_aluOp = ALU_SRL;
                        end else if (w_f7Alt) begin
                            w_class = C_ALU_I;
                            w_aluOp = ALU_SRA;
                        end
                    end
                    default: w_class = C_ILLEGAL;
                endcase
            end
            OP_LOAD:   if (w_funct3 == 3'b010) w_class = C_LOAD;
            OP_STORE:  if (w_funct3 == 3'b010) w_class = C_STORE;
            OP_BRANCH: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001 ||
                    w_funct3 == 3'b100 || w_funct3 == 3'b101) begin
                    w_class = C_BRANCH;
                    w_aluOp = w_funct3[2] ? ALU_SLT : ALU_SUB;
                end
            end
            OP_JAL:    w_class = C_JAL;
            OP_JALR:   if (w_funct3 == 3'b000) w_class = C_JALR;
            OP_LUI:    w_class = C_LUI;
            OP_AUIPC:  w_class = C_AUIPC;
            default:   w_class = C_ILLEGAL;
        endcase
    end

    // Branch decision from the ALU flags: equality via SUB/zero, signed
    // less-than via SLT/bit 0.
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = alu_zero;
            3'b001:  w_taken = ~alu_zero;
            3'b100:  w_taken = alu_lsb;
            3'b101:  w_taken = ~alu_lsb;
            default: w_taken = 1'b0;
        endcase
    end

    // State register: memory states wait on mem_rvalid, TRAP holds until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  if (mem_rvalid) r_state <= S_DECODE;
                S_DECODE: r_state <= (w_class == C_ILLEGAL) ? S_TRAP : S_EXEC;
                S_EXEC: begin
                    case (w_class)
                        C_ALU_R, C_ALU_I, C_LUI, C_AUIPC: r_state <= S_WB;
                        C_LOAD, C_STORE:                  r_state <= S_MEM;
                        C_BRANCH, C_JAL, C_JALR:          r_state <= S_FETCH;
                        default:                          r_state <= S_TRAP;
                    endcase
                end
                S_MEM: begin
                    if (mem_rvalid) r_state <= (w_class == C_STORE) ? S_FETCH : S_WB;
                end
                S_WB:     r_state <= S_FETCH;
                S_TRAP:   r_state <= S_TRAP;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // Per-state control outputs; gated by rst_n so every output drops to its
    // idle value the moment reset asserts, without waiting for a clock.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        alu_ctrl  = ALU_ADD;
        alu_a_sel = 2'd0;
        alu_b_sel = 2'd0;
        imm_sel   = 3'd0;
        aluout_we = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        illegal   = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd2;
                    ir_we     = mem_rvalid;
                    pc_we     = mem_rvalid;
                end
                S_DECODE: begin
                    alu_a_sel = 2'd1;
                    alu_b_sel = 2'd1;
                    imm_sel   = 3'd2;
                    aluout_we = 1'b1;
                end
                S_EXEC: begin
                    case (w_class)
                        C_ALU_R: begin
                            alu_ctrl  = w_aluOp;
                            aluout_we = 1'b1;
                        end
                        C_ALU_I: begin
                            alu_ctrl  = w_aluOp;
                            alu_b_sel = 2'd1;
                            aluout_we = 1'b1;
                        end
                        C_LOAD, C_STORE: begin
                            alu_b_sel = 2'd1;
                            imm_sel   = (w_class == C_STORE) ? 3'd1 : 3'd0;
                            aluout_we = 1'b1;
                        end
                        C_BRANCH: begin
                            alu_ctrl = w_aluOp;
                            pc_we    = w_taken;
                            pc_src   = w_taken;
                        end
                        C_JAL: begin
                            alu_a_sel = 2'd1;
                            alu_b_sel = 2'd1;
                            imm_sel   = 3'd4;
                            pc_we     = 1'b1;
                            reg_we    = 1'b1;
                            wb_sel    = 2'd2;
                        end
                        C_JALR: begin
                            alu_b_sel = 2'd1;
                            pc_we     = 1'b1;
                            reg_we    = 1'b1;
                            wb_sel    = 2'd2;
                        end
                        C_LUI: begin
                            alu_ctrl  = ALU_PASS_B;
                            alu_a_sel = 2'd2;
                            alu_b_sel = 2'd1;
                            imm_sel   = 3'd3;
                            aluout_we = 1'b1;
                        end
                        C_AUIPC: begin
                            alu_a_sel = 2'd1;
                            alu_b_sel = 2'd1;
                            imm_sel   = 3'd3;
                            aluout_we = 1'b1;
                        end
                        default: aluout_we = 1'b0;
                    endcase
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (w_class == C_STORE);
                end
                S_WB: begin
                    reg_we = 1'b1;
                    wb_sel = (w_class == C_LOAD) ? 2'd1 : 2'd0;
                end
                S_TRAP:  illegal = 1'b1;
                default: illegal = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed, table-driven bench for the multi-cycle
// control FSM, with hand-written sequences for wait states, traps and
// reset in the middle of an instruction.
module tb_multicycle_ctrl;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    localparam logic [3:0] aluAdd   = 4'd0;
    localparam logic [3:0] aluSub   = 4'd1;
    localparam logic [3:0] aluSll   = 4'd2;
    localparam logic [3:0] aluSlt   = 4'd3;
    localparam logic [3:0] aluXor   = 4'd4;
    localparam logic [3:0] aluSra   = 4'd6;
    localparam logic [3:0] aluAnd   = 4'd8;
    localparam logic [3:0] aluPassB = 4'd9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        alu_zero;
    logic        alu_lsb;
    logic        mem_rvalid;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic [3:0]  alu_ctrl;
    logic [1:0]  alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic [2:0]  imm_sel;
    logic        aluout_we;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [31:0] reset_pc;
    logic        illegal;

    int compared   = 0;
    int mismatched = 0;

    multicycle_ctrl #(.RESET_PC(TB_RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .alu_zero(alu_zero), .alu_lsb(alu_lsb), .mem_rvalid(mem_rvalid),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_ctrl(alu_ctrl), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .imm_sel(imm_sel), .aluout_we(aluout_we), .reg_we(reg_we),
        .wb_sel(wb_sel), .reset_pc(reset_pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        logic        l;
        logic        pcWe;
        logic        pcSrc;
        logic        aoWe;
        logic        rWe;
        logic [3:0]  ctrl;
        logic [1:0]  aSel;
        logic [1:0]  bSel;
        logic [2:0]  imm;
        logic [1:0]  wb;
        int          cycles;
    } vec_t;

    vec_t vecs[21];

    function automatic logic [21:0] actualOut();
        return {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_ctrl,
                alu_a_sel, alu_b_sel, imm_sel, aluout_we, reg_we, wb_sel, illegal};
    endfunction

    function automatic logic [21:0] expOut(
        input logic mReq, input logic mWe, input logic aSelAddr,
        input logic irWe, input logic pcWe, input logic pcSrc,
        input logic [3:0] ctrl, input logic [1:0] aSel, input logic [1:0] bSel,
        input logic [2:0] imm, input logic aoWe, input logic rWe,
        input logic [1:0] wb, input logic ill);
        return {mReq, mWe, aSelAddr, irWe, pcWe, pcSrc, ctrl, aSel, bSel,
                imm, aoWe, rWe, wb, ill};
    endfunction

    task automatic checkOutput(input string name, input logic [21:0] got,
                               input logic [21:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %06h required %06h", name, got, want);
        end
    endtask

    task automatic checkWord(input string name, input logic [31:0] got,
                             input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, got, want);
        end
    endtask

    // Reset, load the IR, release reset just after a falling edge: cycle 0 (FETCH)
    task automatic applyStimulus(input logic [31:0] ins, input logic z,
                                 input logic l, input logic rv);
        rst_n      = 1'b0;
        instr      = ins;
        alu_zero   = z;
        alu_lsb    = l;
        mem_rvalid = rv;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic nextCycle(input logic rv);
        @(negedge clk);
        mem_rvalid = rv;
        #1;
    endtask

    logic [21:0] fetchGo, fetchWait, decodeOut, resetOut;
    int k;
    int badCount;
    logic found;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{32'h00500093, 0, 0, 0, 0, 1, 0, aluAdd,   2'd0, 2'd1, 3'd0, 2'd0, 4};
        vecs[1]  = '{32'h002081B3, 0, 0, 0, 0, 1, 0, aluAdd,   2'd0, 2'd0, 3'd0, 2'd0, 4};
        vecs[2]  = '{32'h402081B3, 0, 0, 0, 0, 1, 0, aluSub,   2'd0, 2'd0, 3'd0, 2'd0, 4};
        vecs[3]  = '{32'h0020C1B3, 0, 0, 0, 0, 1, 0, aluXor,   2'd0, 2'd0, 3'd0, 2'd0, 4};
        vecs[4]  = '{32'h4020D1B3, 0, 0, 0, 0, 1, 0, aluSra,   2'd0, 2'd0, 3'd0, 2'd0, 4};
        vecs[5]  = '{32'h0020A1B3, 0, 0, 0, 0, 1, 0, aluSlt,   2'd0, 2'd0, 3'd0, 2'd0, 4};
        vecs[6]  = '{32'h00309093, 0, 0, 0, 0, 1, 0, aluSll,   2'd0, 2'd1, 3'd0, 2'd0, 4};
        vecs[7]  = '{32'h0FF0F093, 0, 0, 0, 0, 1, 0, aluAnd,   2'd0, 2'd1, 3'd0, 2'd0, 4};
        vecs[8]  = '{32'h123452B7, 0, 0, 0, 0, 1, 0, aluPassB, 2'd2, 2'd1, 3'd3, 2'd0, 4};
        vecs[9]  = '{32'h00001297, 0, 0, 0, 0, 1, 0, aluAdd,   2'd1, 2'd1, 3'd3, 2'd0, 4};
        vecs[10] = '{32'h0000A103, 0, 0, 0, 0, 1, 0, aluAdd,   2'd0, 2'd1, 3'd0, 2'd0, 5};
        vecs[11] = '{32'h0020A223, 0, 0, 0, 0, 1, 0, aluAdd,   2'd0, 2'd1, 3'd1, 2'd0, 4};
        vecs[12] = '{32'h00208463, 1, 0, 1, 1, 0, 0, aluSub,   2'd0, 2'd0, 3'd0, 2'd0, 3};
        vecs[13] = '{32'h00208463, 0, 0, 0, 0, 0, 0, aluSub,   2'd0, 2'd0, 3'd0, 2'd0, 3};
        vecs[14] = '{32'h00209463, 0, 0, 1, 1, 0, 0, aluSub,   2'd0, 2'd0, 3'd0, 2'd0, 3};
        vecs[15] = '{32'h0020C463, 0, 1, 1, 1, 0, 0, aluSlt,   2'd0, 2'd0, 3'd0, 2'd0, 3};
        vecs[16] = '{32'h0020C463, 0, 0, 0, 0, 0, 0, aluSlt,   2'd0, 2'd0, 3'd0, 2'd0, 3};
        vecs[17] = '{32'h0020D463, 0, 0, 1, 1, 0, 0, aluSlt,   2'd0, 2'd0, 3'd0, 2'd0, 3};
        vecs[18] = '{32'h0020D463, 0, 1, 0, 0, 0, 0, aluSlt,   2'd0, 2'd0, 3'd0, 2'd0, 3};
        vecs[19] = '{32'h008000EF, 0, 0, 1, 0, 0, 1, aluAdd,   2'd1, 2'd1, 3'd4, 2'd2, 3};
        vecs[20] = '{32'h000100E7, 0, 0, 1, 0, 0, 1, aluAdd,   2'd0, 2'd1, 3'd0, 2'd2, 3};

        fetchGo   = expOut(1, 0, 0, 1, 1, 0, aluAdd, 2'd1, 2'd2, 3'd0, 0, 0, 2'd0, 0);
        fetchWait = expOut(1, 0, 0, 0, 0, 0, aluAdd, 2'd1, 2'd2, 3'd0, 0, 0, 2'd0, 0);
        decodeOut = expOut(0, 0, 0, 0, 0, 0, aluAdd, 2'd1, 2'd1, 3'd2, 1, 0, 2'd0, 0);
        resetOut  = expOut(0, 0, 0, 0, 0, 0, aluAdd, 2'd0, 2'd0, 3'd0, 0, 0, 2'd0, 0);

        // Reset values
        rst_n = 1'b0; instr = 32'h0; alu_zero = 1'b0; alu_lsb = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checkOutput("resetOutputs", actualOut(), resetOut);
        checkWord("resetPc", reset_pc, TB_RESET_PC);

        // Table: EXEC-cycle outputs and total cycle count with zero-wait memory
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].ins, vecs[i].z, vecs[i].l, 1'b1);
            nextCycle(1'b1);
            nextCycle(1'b1);
            checkOutput($sformatf("exec[%0d]", i), actualOut(),
                        expOut(0, 0, 0, 0, vecs[i].pcWe, vecs[i].pcSrc, vecs[i].ctrl,
                               vecs[i].aSel, vecs[i].bSel, vecs[i].imm, vecs[i].aoWe,
                               vecs[i].rWe, vecs[i].wb, 0));
            k = 2;
            found = 1'b0;
            while (!found && k < 20) begin
                nextCycle(1'b1);
                k++;
                if (mem_req === 1'b1 && addr_sel === 1'b0) found = 1'b1;
            end
            checkWord($sformatf("cycles[%0d]", i), k, vecs[i].cycles);
        end

        // addi x1,x0,5: full sequence
        applyStimulus(32'h00500093, 0, 0, 1'b1);
        checkOutput("addiFetch", actualOut(), fetchGo);
        nextCycle(1'b1);
        checkOutput("addiDecode", actualOut(), decodeOut);
        nextCycle(1'b1);
        nextCycle(1'b1);
        checkOutput("addiWb", actualOut(),
                    expOut(0, 0, 0, 0, 0, 0, aluAdd, 2'd0, 2'd0, 3'd0, 0, 1, 2'd0, 0));
        nextCycle(1'b1);
        checkOutput("addiNextFetch", actualOut(), fetchGo);

        // lw with three wait cycles in MEM: 8 cycles total
        applyStimulus(32'h0000A103, 0, 0, 1'b1);
        nextCycle(1'b1);
        nextCycle(1'b1);
        for (int w = 0; w < 3; w++) begin
            nextCycle(1'b0);
            checkOutput($sformatf("lwMemWait%0d", w), actualOut(),
                        expOut(1, 0, 1, 0, 0, 0, aluAdd, 2'd0, 2'd0, 3'd0, 0, 0, 2'd0, 0));
        end
        nextCycle(1'b1);
        checkOutput("lwMemAck", actualOut(),
                    expOut(1, 0, 1, 0, 0, 0, aluAdd, 2'd0, 2'd0, 3'd0, 0, 0, 2'd0, 0));
        nextCycle(1'b1);
        checkOutput("lwWb", actualOut(),
                    expOut(0, 0, 0, 0, 0, 0, aluAdd, 2'd0, 2'd0, 3'd0, 0, 1, 2'd1, 0));
        nextCycle(1'b1);
        checkOutput("lwNextFetch", actualOut(), fetchGo);

        // SLTU traps after DECODE and stays quiet until reset
        applyStimulus(32'h0020B1B3, 0, 0, 1'b1);
        nextCycle(1'b1);
        checkOutput("sltuDecode", actualOut(), decodeOut);
        badCount = 0;
        for (int t = 0; t < 20; t++) begin
            nextCycle(1'b1);
            if (actualOut() !== expOut(0, 0, 0, 0, 0, 0, aluAdd, 2'd0, 2'd0, 3'd0, 0, 0, 2'd0, 1))
                badCount++;
        end
        checkWord("trapHoldBadCycles", badCount, 0);
        #2 rst_n = 1'b0;
        #1 checkOutput("trapResetClears", actualOut(), resetOut);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("trapRestartFetch", actualOut(), fetchGo);

        // sw: FETCH wait, then reset asserted in the middle of MEM
        applyStimulus(32'h0020A223, 0, 0, 1'b0);
        checkOutput("swFetchWait", actualOut(), fetchWait);
        nextCycle(1'b1);
        checkOutput("swFetchAck", actualOut(), fetchGo);
        nextCycle(1'b1);
        nextCycle(1'b1);
        nextCycle(1'b0);
        checkOutput("swMem", actualOut(),
                    expOut(1, 1, 1, 0, 0, 0, aluAdd, 2'd0, 2'd0, 3'd0, 0, 0, 2'd0, 0));
        #2 rst_n = 1'b0;
        #1 checkOutput("swAsyncReset", actualOut(), resetOut);
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("swRestartFetch", actualOut(), fetchGo);
        nextCycle(1'b1);
        checkOutput("swRestartDecode", actualOut(), decodeOut);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM that issues operations to the existing RV32I ALU and consumes its result flags. It sequences each instruction through fetch, decode, execute, memory and writeback. Per cycle it drives `alu_ctrl` (alu_encoding codes), operand and writeback selects, register/PC/IR write enables and a request/valid memory handshake. It replaces the single-cycle decode path when the core moves to a shared instruction/data memory.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: value the datapath loads into the PC on reset. It is passed through to the datapath as `reset_pc`; the controller itself does not store it.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `instr`  in  32  current IR contents from the datapath
- `alu_zero`  in  1  ALU `zero` flag
- `alu_lsb`  in  1  bit 0 of ALU `alu_res`, used for the SLT result
- `mem_rvalid`  in  1  memory read data / write ack valid
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  1 = store
- `addr_sel`  out  1  0 = PC, 1 = ALUOut register
- `ir_we`  out  1  load IR from memory read data
- `pc_we`  out  1  load PC from the `pc_src` mux
- `pc_src`  out  1  0 = ALU result, 1 = ALUOut register
- `alu_ctrl`  out  4  ALU operation code from alu_encoding
- `alu_a_sel`  out  2  0 = rs1, 1 = PC, 2 = zero
- `alu_b_sel`  out  2  0 = rs2, 1 = immediate, 2 = constant 4
- `imm_sel`  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J
- `aluout_we`  out  1  capture ALU result into ALUOut
- `reg_we`  out  1  register file write
- `wb_sel`  out  2  0 = ALUOut, 1 = memory data register, 2 = PC
- `reset_pc`  out  32  constant `RESET_PC`
- `illegal`  out  1  sticky illegal-instruction flag

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded from the state and `instr`.
- FETCH:
  - Drives `mem_req=1`, `addr_sel=0`.
  - Holds until `mem_rvalid`. In that cycle: `ir_we=1`, `pc_we=1`, `pc_src=0`, ALU computes PC+4 (`alu_a_sel=1`, `alu_b_sel=2`, ALU_ADD).
  - Next state is DECODE.
- DECODE:
  - ALU computes PC_old+imm_B into ALUOut: `alu_a_sel=1`, `imm_sel=2`, ALU_ADD, `aluout_we=1`.
  - PC_old is formed by the datapath as PC-4.
  - An unsupported opcode/funct goes to TRAP. This includes SLTU/SLTIU, BLTU/BGEU, FENCE and SYSTEM, because the ALU has no unsigned compare.
  - Any other instruction goes to EXEC.
- EXEC:
  - R/I-ALU: ALU op from funct3/funct7; `aluout_we=1`; next WB.
  - LW/SW: ALU_ADD rs1+imm (I or S); `aluout_we=1`; next MEM.
  - Branch:
    - BEQ/BNE: ALU_SUB rs1-rs2; taken when `alu_zero` is 1 (BEQ) or 0 (BNE).
    - BLT/BGE: ALU_SLT; taken when `alu_lsb` is 1 (BLT) or 0 (BGE).
    - If taken: `pc_we=1`, `pc_src=1`.
    - Next FETCH.
  - JAL: `reg_we=1`, `wb_sel=2` (PC already holds the link value). ALU computes ALUOut-style target PC_old+imm_J and writes it with `pc_we=1`, `pc_src=0`. Next FETCH.
  - JALR: same as JAL except the target is rs1+imm_I with bit 0 forced to 0 by the datapath.
  - LUI: ALU_PASS_B of imm_U; `aluout_we=1`; next WB.
  - AUIPC: PC_old+imm_U; `aluout_we=1`; next WB.
- MEM:
  - `mem_req=1`, `addr_sel=1`, `mem_we`=store.
  - Holds until `mem_rvalid`. Then a store goes to FETCH and a load goes to WB.
- WB: `reg_we=1`. `wb_sel=1` for a load, else 0. Next FETCH.
- TRAP:
  - `illegal=1`; all enables and `mem_req` are 0.
  - The state holds until reset.
- Destination x0: the controller still pulses `reg_we`; the register file discards writes to x0.

## Timing
- Reset:
  - While `rst_n` is low, the state is forced to FETCH.
  - `mem_req`, `mem_we`, `ir_we`, `pc_we`, `aluout_we`, `reg_we` and `illegal` are 0.
  - All select outputs are 0; `alu_ctrl`=ALU_ADD.
- The first `mem_req` is asserted in the first cycle after `rst_n` deasserts.
- Minimum cycles with zero-wait memory (`mem_rvalid` in the same cycle as `mem_req`):
  - Branch, JAL, JALR: 3
  - Store: 4
  - R/I/LUI/AUIPC: 4
  - Load: 5
- Each memory wait cycle adds 1 cycle. While waiting, outputs are held stable and every write enable is 0.
- `mem_req` stays high until `mem_rvalid`. The request is never withdrawn.
- A `mem_rvalid` outside FETCH/MEM is ignored.
- Reset mid-instruction aborts the instruction immediately with no partial writes. The memory responder shares `rst_n`.
- All write enables are single-cycle pulses.

## Test plan
- Reset, then `rst_n` high with `instr`=0x00500093 (addi x1,x0,5) and zero-wait memory -> FETCH/DECODE/EXEC/WB take exactly 4 cycles. In EXEC: ALU_ADD, `alu_b_sel=1`. `reg_we` pulses once in WB with `wb_sel=0`.
- `instr`=0x0000A103 (lw x2,0(x1)), with `mem_rvalid` delayed 3 cycles in MEM -> 8 cycles total. `mem_req`/`addr_sel=1` are held for 4 cycles. WB uses `wb_sel=1`.
- BEQ 0x00208463:
  - `alu_zero`=1 in EXEC -> `pc_we=1`, `pc_src=1`, 3 cycles.
  - `alu_zero`=0 in EXEC -> `pc_we=0`.
  - Repeat for BLT with `alu_lsb` 1 and 0.
- JAL 0x008000EF -> in EXEC: `reg_we=1`, `wb_sel=2`, `pc_we=1`, `pc_src=0`, `imm_sel=4`. Next state is FETCH.
- SLTU 0x0020B1B3 -> after DECODE, `illegal=1` and `mem_req` stays 0 for 20 cycles. Pulsing `rst_n` low clears `illegal` and fetch restarts.
- Assert `rst_n` low during MEM of a store -> all outputs go to reset values asynchronously with no `mem_we` pulse completing. After release, FETCH begins on the next cycle.
